// File: rtl/io_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_uart_pkg
// Description : Shared constants and types for the dual-lane UART TX queue
//               IO slave. Holds the IO word-address bit indices, the status
//               word bit positions and the halt sequencing state type.
// Revision    : 1.0 - initial release
// ============================================================================
package io_uart_pkg;

    // One-hot bit positions within the word address addr[15:2]
    localparam int IO_LEDS      = 0;
    localparam int IO_UART_DAT  = 1;
    localparam int IO_UART_CTRL = 2;
    localparam int IO_HALT      = 3;

    // Bit positions within the status read word
    localparam int BUSY_BIT = 9;
    localparam int OVF_BIT  = 10;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

endpackage : io_uart_pkg
`default_nettype wire

// File: rtl/io_uart_txq_fifo2w1r.sv
`default_nettype none
// ============================================================================
// Module      : txq_fifo2w1r
// Description : Byte FIFO with two write ports and one read port. When both
//               write ports fire in one cycle, port a is older and lands in
//               the lower slot. Bytes that do not fit are dropped and flagged.
//               Free-space decisions use the occupancy before any same-cycle
//               read, so a full FIFO never accepts a byte even while popping.
// Ports       : clk, resetn      - clock, synchronous active-low reset
//               wr_a/din_a       - write port a (older)
//               wr_b/din_b       - write port b (younger)
//               rd               - pop request (ignored when empty)
//               dout             - head byte, zero when empty
//               empty            - no bytes held
//               free             - free entries
//               dropped          - a requested write was rejected this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module txq_fifo2w1r #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_a,
    input  logic [7:0]    din_a,
    input  logic          wr_b,
    input  logic [7:0]    din_b,
    input  logic          rd,
    output logic [7:0]    dout,
    output logic          empty,
    output logic [AW:0]   free,
    output logic          dropped
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic          w_acc_a;
    logic          w_acc_b;
    logic          w_pop;
    logic [AW-1:0] w_wptr_b;

    assign free  = c_depth - r_count;
    assign empty = (r_count == '0);

    // b needs one more free slot than a already consumed this cycle
    assign w_acc_a  = wr_a && (free != '0);
    assign w_acc_b  = wr_b && (free > (AW+1)'(w_acc_a));
    assign w_pop    = rd && !empty;
    assign w_wptr_b = r_wptr + AW'(w_acc_a);

    assign dropped = (wr_a && !w_acc_a) || (wr_b && !w_acc_b);
    assign dout    = empty ? 8'h00 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_acc_a) begin
            r_mem[r_wptr] <= din_a;
        end
        if (w_acc_b) begin
            r_mem[w_wptr_b] <= din_b;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_acc_a) + AW'(w_acc_b);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_acc_a) + (AW+1)'(w_acc_b) - (AW+1)'(w_pop);
        end
    end

endmodule : txq_fifo2w1r
`default_nettype wire

// File: rtl/io_uart_txq.sv
`default_nettype none
// ============================================================================
// Module      : io_uart_txq
// Description : Dual-lane memory-mapped IO slave. Merges UART byte writes from
//               both core lanes (a older than b) into a shared FIFO drained
//               to the UART emitter, and owns the LED register, UART status
//               readback and halt sequencing (halt waits for the queue to
//               empty).
// Ports       : clk, resetn                 - clock, sync active-low reset
//               a_IO_mem_* / b_IO_mem_*     - lane a / lane b IO bus
//               uart_data/valid/ready       - byte stream to emitter
//               leds                        - LED register
//               halt                        - system stop
// Revision    : 1.0 - initial release
// ============================================================================
module io_uart_txq
    import io_uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        a_IO_mem_wr,
    input  logic [31:0] a_IO_mem_addr,
    input  logic [31:0] a_IO_mem_wdata,
    output logic [31:0] a_IO_mem_rdata,
    input  logic        b_IO_mem_wr,
    input  logic [31:0] b_IO_mem_addr,
    input  logic [31:0] b_IO_mem_wdata,
    output logic [31:0] b_IO_mem_rdata,
    output logic [7:0]  uart_data,
    output logic        uart_valid,
    input  logic        uart_ready,
    output logic [7:0]  leds,
    output logic        halt
);

    logic [13:0]  w_a_word;
    logic [13:0]  w_b_word;
    logic         w_a_uart;
    logic         w_b_uart;
    logic         w_halt_req;
    logic         w_empty;
    logic [AW:0]  w_free;
    logic         w_dropped;
    logic [31:0]  w_status;
    logic         w_unused;

    halt_state_t  r_state;
    halt_state_t  w_state_next;
    logic         r_ovf;
    logic [7:0]   r_leds;

    assign w_a_word = a_IO_mem_addr[15:2];
    assign w_b_word = b_IO_mem_addr[15:2];

    // Once halted the UART path is closed; only LED writes still land
    assign w_a_uart = a_IO_mem_wr && w_a_word[IO_UART_DAT] && (r_state != HALTED);
    assign w_b_uart = b_IO_mem_wr && w_b_word[IO_UART_DAT] && (r_state != HALTED);
    assign w_halt_req = (a_IO_mem_wr && w_a_word[IO_HALT]) ||
                        (b_IO_mem_wr && w_b_word[IO_HALT]);

    txq_fifo2w1r #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_a    (w_a_uart),
        .din_a   (a_IO_mem_wdata[7:0]),
        .wr_b    (w_b_uart),
        .din_b   (b_IO_mem_wdata[7:0]),
        .rd      (uart_ready),
        .dout    (uart_data),
        .empty   (w_empty),
        .free    (w_free),
        .dropped (w_dropped)
    );

    assign uart_valid = !w_empty;

    // Busy while fewer than two slots are free, so a single poll guarantees
    // room for a same-cycle pair from both lanes
    always_comb begin
        w_status           = '0;
        w_status[BUSY_BIT] = (w_free < (AW+1)'(2));
        w_status[OVF_BIT]  = r_ovf;
    end

    assign a_IO_mem_rdata = w_a_word[IO_UART_CTRL] ? w_status : '0;
    assign b_IO_mem_rdata = w_b_word[IO_UART_CTRL] ? w_status : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_leds <= '0;
            r_ovf  <= 1'b0;
        end else begin
            // b is the younger instruction, so its LED write takes effect last
            if (b_IO_mem_wr && w_b_word[IO_LEDS]) begin
                r_leds <= b_IO_mem_wdata[7:0];
            end else if (a_IO_mem_wr && w_a_word[IO_LEDS]) begin
                r_leds <= a_IO_mem_wdata[7:0];
            end
            if (w_dropped) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign leds = r_leds;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (w_halt_req) w_state_next = DRAIN;
            DRAIN:   if (w_empty && uart_ready) w_state_next = HALTED;
            HALTED:  w_state_next = HALTED;
            default: w_state_next = RUN;
        endcase
    end

    assign halt = (r_state == HALTED);

    assign w_unused = ^{a_IO_mem_addr[31:16], a_IO_mem_addr[1:0], w_a_word[13:4],
                        b_IO_mem_addr[31:16], b_IO_mem_addr[1:0], w_b_word[13:4],
                        a_IO_mem_wdata[31:8], b_IO_mem_wdata[31:8]};

endmodule : io_uart_txq
`default_nettype wire

// File: tb/tb_io_uart_txq.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_uart_txq
// Description : Self-checking bench for io_uart_txq. A queue-based model of
//               the IO slave is compared against the DUT every cycle, and
//               directed scenarios pin the model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_uart_txq;

    localparam int DEPTH = 8;
    localparam logic [31:0] A_LED  = 32'h04;
    localparam logic [31:0] A_UART = 32'h08;
    localparam logic [31:0] A_STAT = 32'h10;
    localparam logic [31:0] A_HALT = 32'h20;

    logic        clk = 1'b0;
    logic        resetn;
    logic        a_wr, b_wr;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic [7:0]  uart_data;
    logic        uart_valid;
    logic        uart_ready;
    logic [7:0]  leds;
    logic        halt;

    always #5 clk = ~clk;

    io_uart_txq #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .a_IO_mem_wr    (a_wr),
        .a_IO_mem_addr  (a_addr),
        .a_IO_mem_wdata (a_wdata),
        .a_IO_mem_rdata (a_rdata),
        .b_IO_mem_wr    (b_wr),
        .b_IO_mem_addr  (b_addr),
        .b_IO_mem_wdata (b_wdata),
        .b_IO_mem_rdata (b_rdata),
        .uart_data      (uart_data),
        .uart_valid     (uart_valid),
        .uart_ready     (uart_ready),
        .leds           (leds),
        .halt           (halt)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    logic [7:0] log_q[$];
    bit         m_ovf  = 1'b0;
    logic [7:0] m_leds = 8'h00;
    int         m_st   = 0;      // 0 running, 1 draining, 2 halted
    int         n0, mfree;
    bit         mpop;

    always @(posedge clk) begin
        if (!resetn) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_leds = 8'h00;
            m_st   = 0;
        end else begin
            n0    = mq.size();
            mfree = DEPTH - n0;
            mpop  = (n0 > 0) && uart_ready;
            if (m_st != 2) begin
                if (a_wr && a_addr[3]) begin
                    if (mfree > 0) begin mq.push_back(a_wdata[7:0]); mfree--; end
                    else m_ovf = 1'b1;
                end
                if (b_wr && b_addr[3]) begin
                    if (mfree > 0) begin mq.push_back(b_wdata[7:0]); mfree--; end
                    else m_ovf = 1'b1;
                end
            end
            if (mpop) void'(mq.pop_front());
            if (a_wr && a_addr[2]) m_leds = a_wdata[7:0];
            if (b_wr && b_addr[2]) m_leds = b_wdata[7:0];
            if (m_st == 0 && ((a_wr && a_addr[5]) || (b_wr && b_addr[5]))) m_st = 1;
            else if (m_st == 1 && n0 == 0 && uart_ready) m_st = 2;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [31:0] ad);
        logic [31:0] r;
        r = 32'h0;
        if (ad[4]) begin
            r[10] = m_ovf;
            r[9]  = (DEPTH - mq.size()) < 2;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid",   {31'b0, uart_valid}, {31'b0, mq.size() != 0});
            chk("data",    {24'b0, uart_data}, (mq.size() != 0) ? {24'b0, mq[0]} : 32'h0);
            chk("leds",    {24'b0, leds}, {24'b0, m_leds});
            chk("halt",    {31'b0, halt}, {31'b0, m_st == 2});
            chk("a_rdata", a_rdata, exp_rd(a_addr));
            chk("b_rdata", b_rdata, exp_rd(b_addr));
            if (uart_valid && uart_ready) log_q.push_back(uart_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                         input logic bw, input logic [31:0] ba, input logic [31:0] bd);
        a_wr = aw; a_addr = aa; a_wdata = ad;
        b_wr = bw; b_addr = ba; b_wdata = bd;
        @(posedge clk); #1;
        a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic lit_status(input string nm, input logic [31:0] exp);
        a_addr = A_STAT; #1;
        chk(nm, a_rdata, exp);
        a_addr = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; uart_ready = 1'b0;
        a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk("rst_valid", {31'b0, uart_valid}, 32'h0);
        chk("rst_halt",  {31'b0, halt}, 32'h0);
        chk("rst_leds",  {24'b0, leds}, 32'h0);
        lit_status("rst_status", 32'h0);

        // Ordering across lanes
        log_q.delete();
        uart_ready = 1'b1;
        drive(1, A_UART, 32'h41, 0, 0, 0);
        drive(1, A_UART, 32'h42, 1, A_UART, 32'h43);
        idle(5);
        chk("ord_cnt", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("ord_0", {24'b0, log_q[0]}, 32'h41);
            chk("ord_1", {24'b0, log_q[1]}, 32'h42);
            chk("ord_2", {24'b0, log_q[2]}, 32'h43);
        end
        chk("ord_valid_off", {31'b0, uart_valid}, 32'h0);

        // Busy and overflow
        uart_ready = 1'b0;
        drive(1, A_UART, 32'h10, 1, A_UART, 32'h11);
        drive(1, A_UART, 32'h12, 1, A_UART, 32'h13);
        drive(1, A_UART, 32'h14, 1, A_UART, 32'h15);
        lit_status("st_cnt6", 32'h000);
        drive(1, A_UART, 32'h16, 0, 0, 0);
        lit_status("st_cnt7", 32'h200);
        drive(1, A_UART, 32'h55, 1, A_UART, 32'h66);
        lit_status("st_ovf", 32'h600);

        // Full FIFO: push rejected even while popping
        log_q.delete();
        uart_ready = 1'b1;
        drive(1, A_UART, 32'h77, 0, 0, 0);
        uart_ready = 1'b0;
        lit_status("st_full_pop", 32'h600);
        uart_ready = 1'b1;
        idle(10);
        chk("full_cnt", log_q.size(), 8);
        if (log_q.size() == 8) begin
            chk("full_first", {24'b0, log_q[0]}, 32'h10);
            chk("full_last",  {24'b0, log_q[7]}, 32'h55);
        end

        // Wrap: 20 bytes with ready toggling
        do_reset();
        log_q.delete();
        for (int i = 0; i < 20; i++) begin
            uart_ready = 1'b0;
            if (i % 2 == 0) drive(1, A_UART, i, 0, 0, 0);
            else            drive(0, 0, 0, 1, A_UART, i);
            uart_ready = 1'b1;
            idle(1);
        end
        idle(4);
        chk("wrap_cnt", log_q.size(), 20);
        if (log_q.size() == 20) begin
            for (int i = 0; i < 20; i++) chk("wrap_byte", {24'b0, log_q[i]}, i);
        end
        lit_status("wrap_status", 32'h0);

        // Halt waits for the queue to drain
        do_reset();
        uart_ready = 1'b0;
        drive(1, A_UART, 32'h31, 1, A_UART, 32'h32);
        drive(1, A_UART, 32'h33, 0, 0, 0);
        drive(0, 0, 0, 1, A_HALT, 32'h1);
        idle(3);
        chk("halt_wait", {31'b0, halt}, 32'h0);
        uart_ready = 1'b1;
        idle(3);
        chk("halt_after_pops", {31'b0, halt}, 32'h0);
        chk("halt_empty", {31'b0, uart_valid}, 32'h0);
        idle(1);
        chk("halt_rise", {31'b0, halt}, 32'h1);
        drive(1, A_LED, 32'hA5, 0, 0, 0);
        chk("halt_leds", {24'b0, leds}, 32'hA5);
        drive(1, A_UART, 32'h99, 0, 0, 0);
        chk("halt_no_uart", {31'b0, uart_valid}, 32'h0);
        idle(3);
        chk("halt_hold", {31'b0, halt}, 32'h1);

        // Reset mid-drain
        do_reset();
        uart_ready = 1'b0;
        drive(1, A_UART, 32'h01, 1, A_UART, 32'h02);
        drive(1, A_UART, 32'h03, 1, A_UART, 32'h04);
        drive(1, A_LED, 32'h3C, 1, A_HALT, 32'h1);
        idle(2);
        do_reset();
        chk("mid_valid",  {31'b0, uart_valid}, 32'h0);
        chk("mid_halt",   {31'b0, halt}, 32'h0);
        chk("mid_leds",   {24'b0, leds}, 32'h0);
        lit_status("mid_status", 32'h0);

        // Multi-bit address: LED and UART decoded together
        uart_ready = 1'b1;
        drive(1, A_LED | A_UART, 32'h5A, 0, 0, 0);
        chk("multi_leds",  {24'b0, leds}, 32'h5A);
        chk("multi_valid", {31'b0, uart_valid}, 32'h1);
        idle(3);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_io_uart_txq
`default_nettype wire

// File: doc/io_uart_txq.md
Name: io_uart_txq

Overview:
- Dual-lane memory-mapped IO slave between the two IO ports of the dual-issue torv32 core and the corescore_emitter_uart.
- Merges simultaneous UART writes from lane a and lane b into a byte FIFO in program order (lane a older than lane b), then drains it to the emitter with a valid/ready handshake.
- Also owns the LED register, UART status readback and halt sequencing; halt waits until queued bytes have been handed to the emitter.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- AW, $clog2(DEPTH), FIFO pointer width (derived; do not override).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- a_IO_mem_wr  in  1  lane a IO write strobe
- a_IO_mem_addr  in  32  lane a IO address; word address = addr[15:2]
- a_IO_mem_wdata  in  32  lane a write data
- a_IO_mem_rdata  out  32  lane a read data, combinational
- b_IO_mem_wr  in  1  lane b IO write strobe
- b_IO_mem_addr  in  32  lane b IO address
- b_IO_mem_wdata  in  32  lane b write data
- b_IO_mem_rdata  out  32  lane b read data, combinational
- uart_data  out  8  byte to emitter (i_data)
- uart_valid  out  1  byte available (i_valid)
- uart_ready  in  1  emitter accepts (o_ready)
- leds  out  8  LED register
- halt  out  1  simulation/system stop

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn.
- Decode, per lane, on word address w = addr[15:2], one-hot bits:
  - w[0] LED write
  - w[1] UART data write
  - w[2] status read
  - w[3] halt request
- Reset values: leds=0, uart_valid=0, uart_data=0, halt=0. FIFO empty; overflow flag=0; state RUN.
- Status read, both lanes, combinational:
  - rdata = {21'b0, ovf, busy, 9'b0} when w[2], else 0.
  - busy = (free entries < 2), so one poll guarantees room for a same-cycle a+b pair.
- Push rules:
  - Same-cycle a and b UART writes: a's byte goes into slot wptr, b's into wptr+1. Count +2.
  - Single write: count +1.
  - Wrap modulo DEPTH.
- Pop:
  - uart_valid = !empty; uart_data = mem[rptr].
  - Pop on uart_valid & uart_ready.
- Simultaneous push and pop:
  - Free-space check uses the count before the pop.
  - Count update is pushes - pop.
  - Full FIFO plus one push plus one pop is rejected; no same-cycle bypass.
- Overflow:
  - Any byte that does not fit is dropped and sets ovf (sticky until reset).
  - If a fits and b does not, a is kept and b dropped.
  - If one slot is free with only b writing, b is kept.
- LEDs:
  - leds updated from wdata[7:0] the cycle after the write.
  - Same-cycle LED writes on both lanes: b wins (younger).
- Halt FSM (registered):
  - RUN: any lane write with w[3] -> DRAIN.
  - DRAIN: halt=0; UART writes are still accepted. When FIFO empty and uart_ready=1 -> HALTED.
  - HALTED: halt=1, held. Further writes ignored except LEDs. Exit only by reset.
  - Halt request with an empty FIFO and uart_ready=1: halt rises 2 cycles after the write (RUN->DRAIN->HALTED).
- Multi-bit addresses (several w bits set): each decoded function acts independently.
- Reset mid-operation: the queue is flushed, bytes are lost, and the FSM returns to RUN.

Decomposition:
- Package io_uart_pkg:
  - word-address bit indices (IO_LEDS=0, IO_UART_DAT=1, IO_UART_CTRL=2, IO_HALT=3)
  - status bit positions (BUSY_BIT=9, OVF_BIT=10)
  - halt state enum {RUN, DRAIN, HALTED}
- Sub-module txq_fifo2w1r: 2-write/1-read FIFO with per-write enables, count, free output and registered pointers.
- The top holds the decode, LED register, status muxes and halt FSM.

Test Plan:
- Ordering: write 0x41 on lane a only, then the same cycle 0x42 on a and 0x43 on b; hold uart_ready=1 -> emitter sees 0x41, 0x42, 0x43 in order; uart_valid deasserts after the third pop.
- Busy/overflow (DEPTH=8, uart_ready=0): push 6 bytes -> status reads 0x000 then 0x200 at count 7. Then a+b pair (0x55, 0x66) at count 7 -> 0x55 stored, 0x66 dropped, status=0x600.
- Concurrent push/pop: full FIFO, uart_ready=1, lane a writes 0x77 -> byte rejected, ovf set, count becomes 7.
- Wrap: stream 20 bytes 0x00..0x13 with ready toggling every other cycle -> output exactly 0x00..0x13, ovf=0.
- Halt drain: queue 3 bytes, write halt with uart_ready=0 -> halt stays 0; release ready -> halt rises 1 cycle after the last pop and stays high. LED write 0xA5 after halt -> leds=0xA5.
- Reset mid-drain: 4 bytes queued in DRAIN, assert resetn=0 one cycle -> uart_valid=0, halt=0, leds=0, status=0 next cycle.
